// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one word fetch at a time and feeds
// the IF/ID register through an output entry backed by a one-entry skid buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        Stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tag_q, tag_d;
  logic        out_valid_q, out_valid_d;
  entry_t      out_q, out_d;
  logic        skid_valid_q, skid_valid_d;
  entry_t      skid_q, skid_d;

  logic [31:0] redirect_addr;
  logic        req_fire;
  logic        consume;
  logic        rsp_take;
  entry_t      rsp_entry;

  assign redirect_addr = redirect_pc & ~32'h3;
  assign consume       = out_valid_q && !Stall;
  assign rsp_take      = (state_q == ST_WAIT) && imem_rsp_valid;
  assign rsp_entry     = '{instr: imem_rsp_data, pc: tag_q};

  // A request is only issued when the skid is empty, so every accepted request
  // is guaranteed a landing slot and at most one is ever in flight.
  assign imem_req_valid = !rst && (state_q == ST_REQ) && !skid_valid_q;
  // On a redirect cycle the target itself is put on the bus, so a handshake on
  // that edge is a useful fetch of redirect_pc rather than a stale one.
  assign imem_req_addr  = redirect_valid ? redirect_addr : pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign fetch_valid = out_valid_q;
  assign InstrF      = out_valid_q ? out_q.instr : NOP_INSTR;
  assign PCF         = out_q.pc;
  assign PCPlus4F    = out_q.pc + 32'd4;

  // NOTE: every _d signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    tag_d        = tag_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;

    if (redirect_valid) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      if (req_fire) begin
        pc_d    = redirect_addr + 32'd4;
        tag_d   = redirect_addr;
        state_d = ST_WAIT;
      end else begin
        pc_d = redirect_addr;
        // A response still owed by memory must be swallowed before refetching.
        if (state_q != ST_REQ && !imem_rsp_valid) state_d = ST_DRAIN;
        else                                      state_d = ST_REQ;
      end
    end else begin
      if (req_fire) begin
        pc_d    = pc_q + 32'd4;
        tag_d   = pc_q;
        state_d = ST_WAIT;
      end
      if (state_q != ST_REQ && imem_rsp_valid) state_d = ST_REQ;

      if (!out_valid_q || consume) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          out_valid_d  = 1'b1;
          skid_valid_d = rsp_take;
          if (rsp_take) skid_d = rsp_entry;
        end else begin
          out_valid_d = rsp_take;
          if (rsp_take) out_d = rsp_entry;
        end
      end else if (rsp_take) begin
        skid_valid_d = 1'b1;
        skid_d       = rsp_entry;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_REQ;
      pc_q         <= RESET_PC;
      tag_q        <= RESET_PC;
      out_valid_q  <= 1'b0;
      out_q        <= '{instr: NOP_INSTR, pc: RESET_PC};
      skid_valid_q <= 1'b0;
      // NOTE: skid payload is reset too; it is tiny and keeps X out of PCF paths.
      skid_q       <= '{instr: NOP_INSTR, pc: RESET_PC};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      tag_q        <= tag_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a transaction-level memory responder plus an
// in-order program-stream model checks every instruction handed to IF/ID.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        Stall, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] InstrF, PCF, PCPlus4F;
  logic        fetch_valid;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .Stall(Stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .fetch_valid(fetch_valid)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  // memory responder and program-stream model
  bit          mem_busy;
  int          mem_delay;
  logic [31:0] mem_addr;
  int          lat_min, lat_max;
  logic [31:0] exp_pc;
  logic [31:0] hs_log[$];
  int          since_consume;
  bit          prev_hold, prev_stall_hold, prev_redir;
  logic [31:0] prev_addr, prev_instr, prev_pcf;

  task automatic model_reset();
    mem_busy        = 1'b0;
    mem_delay       = 0;
    exp_pc          = RESET_PC;
    since_consume   = 0;
    prev_hold       = 1'b0;
    prev_stall_hold = 1'b0;
    prev_redir      = 1'b0;
  endtask

  task automatic step(input bit st, input bit rdy, input bit redir, input logic [31:0] rpc);
    bit          rsp, fire;
    logic [31:0] addr;
    @(negedge clk);
    Stall          = st;
    imem_req_ready = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rsp            = mem_busy && (mem_delay == 0);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mem_addr) : $urandom;
    #1;
    if (!fetch_valid) check("nop_when_empty", InstrF, NOP);
    if (prev_redir) check("flush_after_redirect", 32'(fetch_valid), 0);
    if (prev_stall_hold) begin
      check("stall_valid", 32'(fetch_valid), 1);
      check("stall_instr", InstrF, prev_instr);
      check("stall_pcf", PCF, prev_pcf);
    end
    if (prev_hold && !redir) begin
      check("req_hold_valid", 32'(imem_req_valid), 1);
      check("req_hold_addr", imem_req_addr, prev_addr);
    end
    if (imem_req_valid) check("req_align", 32'(imem_req_addr[1:0]), 0);
    fire = imem_req_valid && rdy;
    addr = imem_req_addr;
    if (fire) begin
      check("one_outstanding", 32'(mem_busy && !rsp), 0);
      hs_log.push_back(addr);
    end
    if (fetch_valid && !st && !redir) begin
      check("pcf", PCF, exp_pc);
      check("instr", InstrF, mem_word(exp_pc));
      check("pcplus4", PCPlus4F, exp_pc + 32'd4);
      exp_pc        = exp_pc + 32'd4;
      since_consume = 0;
    end else begin
      since_consume++;
    end
    if (redir) exp_pc = rpc & ~32'h3;
    prev_hold       = imem_req_valid && !rdy;
    prev_stall_hold = fetch_valid && st && !redir;
    prev_redir      = redir;
    prev_addr       = imem_req_addr;
    prev_instr      = InstrF;
    prev_pcf        = PCF;
    @(posedge clk);
    if (rsp) mem_busy = 1'b0;
    else if (mem_busy) mem_delay--;
    if (fire) begin
      mem_busy  = 1'b1;
      mem_addr  = addr;
      mem_delay = int'($urandom_range(lat_max, lat_min));
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    int n0, guard;
    rst = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    Stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    lat_min = 0; lat_max = 0;
    model_reset();
    #12;
    check("rst_fetch_valid", 32'(fetch_valid), 0);
    check("rst_instr", InstrF, NOP);
    check("rst_pcf", PCF, RESET_PC);
    check("rst_pcplus4", PCPlus4F, RESET_PC + 32'd4);
    check("rst_req_valid", 32'(imem_req_valid), 0);
    @(posedge clk); #1 rst = 1'b0;

    // straight-line fetch with single-cycle memory
    run(8);
    check("t1_req_cnt", 32'(hs_log.size() >= 3), 1);
    if (hs_log.size() >= 3) begin
      check("t1_req0", hs_log[0], 32'h0);
      check("t1_req1", hs_log[1], 32'h4);
      check("t1_req2", hs_log[2], 32'h8);
    end

    // hold IF/ID for 5 cycles
    n0 = hs_log.size();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    check("t2_extra_req", 32'(hs_log.size() - n0 <= 1), 1);
    check("t2_withheld", 32'(imem_req_valid), 0);
    run(6);

    // memory back-pressure until buffers drain
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    check("t3_drained", 32'(fetch_valid), 0);
    check("t3_nop", InstrF, NOP);
    run(6);

    // redirect while waiting on a slow response
    lat_min = 2; lat_max = 2;
    n0 = hs_log.size(); guard = 0;
    while (hs_log.size() == n0 && guard < 20) begin run(1); guard++; end
    check("t4_got_request", 32'(hs_log.size() != n0), 1);
    hs_log.delete();
    step(1'b0, 1'b1, 1'b1, 32'h0000_0103);
    run(12);
    check("t4_req_cnt", 32'(hs_log.size() >= 1), 1);
    if (hs_log.size() >= 1) check("t4_first_req", hs_log[0], 32'h0000_0100);

    // redirect coinciding with a response, under Stall
    lat_min = 1; lat_max = 1;
    guard = 0;
    while (!(mem_busy && mem_delay == 0) && guard < 20) begin run(1); guard++; end
    check("t5_rsp_pending", 32'(mem_busy && mem_delay == 0), 1);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0200);
    run(10);

    // redirect to the top of the address space
    lat_min = 0; lat_max = 0;
    hs_log.delete();
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    run(10);
    check("t6_req_cnt", 32'(hs_log.size() >= 2), 1);
    if (hs_log.size() >= 2) begin
      check("t6_req0", hs_log[0], 32'hFFFF_FFFC);
      check("t6_req1", hs_log[1], 32'h0000_0000);
    end

    // asynchronous reset with a request in flight
    lat_min = 3; lat_max = 3;
    guard = 0;
    while (!mem_busy && guard < 20) begin run(1); guard++; end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(fetch_valid), 0);
    check("mid_rst_instr", InstrF, NOP);
    check("mid_rst_pcf", PCF, RESET_PC);
    check("mid_rst_req", 32'(imem_req_valid), 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // randomized traffic
    lat_min = 0; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = $urandom;
      if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
      step($urandom_range(3, 0) == 0, $urandom_range(3, 0) != 0,
           $urandom_range(39, 0) == 0, rpc);
      if (since_consume > 80) begin
        check("progress", 32'(since_consume), 0);
        break;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
